// File: rtl/simon_pkt_out_if.sv
// simon_pkt_out_if -- core-side beat bus and host-side packet bus of the
// SIMON output packetiser, bundled so both ends bind to one instance.
//
// Handshake rule (both directions): a transfer happens on a rising clk edge
// where valid && ready are both 1. The producer keeps valid and its payload
// stable until that edge; ready may be asserted independently of valid.
//
// Signals:
//   data_valid / data_ready : core block beat handshake
//   info_in, count_in       : header fields, meaningful on the first beat only
//   data_in                 : one cipher block, [N-1:0] word 0, [2N-1:N] word 1
//   pkt_valid / pkt_ready   : packet handshake towards the transmit logic
//   pkt_out                 : assembled packet, MSB first
//   err                     : one-cycle header error code
//   pkt_count               : header count expected for the next packet
//
// Modports: slave = packetiser view, master = core/host view.
// Macro SIMON_PKT_CHECKSUM_EN widens pkt_out by one checksum byte.
interface simon_pkt_out_if #(
    parameter int N              = 16,
    parameter int BLOCKS_PER_PKT = 2
);
    localparam int W = 2 * BLOCKS_PER_PKT;
`ifdef SIMON_PKT_CHECKSUM_EN
    localparam int PKT_BYTES = 3 + W * N / 8;
`else
    localparam int PKT_BYTES = 2 + W * N / 8;
`endif

    logic                   data_valid;
    logic                   data_ready;
    logic [7:0]             info_in;
    logic [7:0]             count_in;
    logic [2*N-1:0]         data_in;
    logic                   pkt_valid;
    logic                   pkt_ready;
    logic [PKT_BYTES*8-1:0] pkt_out;
    logic [1:0]             err;
    logic [7:0]             pkt_count;

    modport slave (
        input  data_valid, info_in, count_in, data_in, pkt_ready,
        output data_ready, pkt_valid, pkt_out, err, pkt_count
    );

    modport master (
        output data_valid, info_in, count_in, data_in, pkt_ready,
        input  data_ready, pkt_valid, pkt_out, err, pkt_count
    );
endinterface

// File: rtl/simon_pkt_out.sv
// simon_pkt_out -- output packetiser for the SIMON datapath.
// Collects BLOCKS_PER_PKT two-word cipher blocks, validates the header of the
// first beat and presents {info, count, word W-1 .. word 0} as one packet.
//
// Ports:
//   clk     : clock, all state changes on the rising edge
//   nR      : asynchronous active-low reset
//   bus     : simon_pkt_out_if.slave (beat input, packet output, err, pkt_count)
//   state_o : current FSM state (0 IDLE, 1 COLLECT, 2 SEND) for observation
//
// Optional: define SIMON_PKT_CHECKSUM_EN to append an XOR checksum byte.
module simon_pkt_out #(
    parameter int         N              = 16,
    parameter int         BLOCKS_PER_PKT = 2,
    parameter logic [3:0] MODE           = 4'h0
) (
    input  logic                  clk,
    input  logic                  nR,
    simon_pkt_out_if.slave        bus,
    output logic [1:0]            state_o
);
    localparam int W          = 2 * BLOCKS_PER_PKT;
    localparam int BASE_BYTES = 2 + W * N / 8;
    localparam int BW         = (BLOCKS_PER_PKT > 1) ? $clog2(BLOCKS_PER_PKT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SEND    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            info_q, info_d;
    logic [7:0]            hdr_cnt_q, hdr_cnt_d;
    logic [W-1:0][N-1:0]   words_q, words_d;
    logic [BW-1:0]         idx_q, idx_d;
    logic [7:0]            pkt_count_q, pkt_count_d;
    logic [1:0]            err_q, err_d;
    logic                  data_ready_q, data_ready_d;
    logic                  pkt_valid_q, pkt_valid_d;
    logic                  accept;

    assign accept = bus.data_valid && data_ready_q;

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state_q      <= IDLE;
            info_q       <= '0;
            hdr_cnt_q    <= '0;
            words_q      <= '0;
            idx_q        <= '0;
            pkt_count_q  <= '0;
            err_q        <= '0;
            data_ready_q <= 1'b0;
            pkt_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            info_q       <= info_d;
            hdr_cnt_q    <= hdr_cnt_d;
            words_q      <= words_d;
            idx_q        <= idx_d;
            pkt_count_q  <= pkt_count_d;
            err_q        <= err_d;
            data_ready_q <= data_ready_d;
            pkt_valid_q  <= pkt_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        info_d      = info_q;
        hdr_cnt_d   = hdr_cnt_q;
        words_d     = words_q;
        idx_d       = idx_q;
        pkt_count_d = pkt_count_q;
        err_d       = 2'd0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Header checks in priority order; a bad header consumes
                    // the beat and leaves everything else untouched.
                    if (bus.count_in != pkt_count_q) begin
                        err_d = 2'd1;
                    end else if (bus.info_in[3:0] != MODE) begin
                        err_d = 2'd2;
                    end else if (!bus.info_in[4]) begin
                        err_d = 2'd3;
                    end else begin
                        info_d      = bus.info_in;
                        hdr_cnt_d   = bus.count_in;
                        pkt_count_d = pkt_count_q + 8'd1;
                        if (bus.info_in[5]) begin
                            // Zero-fill: header only, no data collected.
                            words_d = '0;
                            state_d = SEND;
                        end else begin
                            words_d[0] = bus.data_in[N-1:0];
                            words_d[1] = bus.data_in[2*N-1:N];
                            idx_d      = BW'(1);
                            state_d    = (BLOCKS_PER_PKT == 1) ? SEND : COLLECT;
                        end
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    for (int b = 0; b < BLOCKS_PER_PKT; b++) begin
                        if (idx_q == BW'(b)) begin
                            words_d[2*b]   = bus.data_in[N-1:0];
                            words_d[2*b+1] = bus.data_in[2*N-1:N];
                        end
                    end
                    if (idx_q == BW'(BLOCKS_PER_PKT - 1)) begin
                        state_d = SEND;
                    end else begin
                        idx_d = idx_q + BW'(1);
                    end
                end
            end
            SEND: begin
                if (pkt_valid_q && bus.pkt_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Both handshake outputs are registered views of the next state, which
        // gives the one-cycle packet latency and ready low for the whole send.
        data_ready_d = (state_d != SEND);
        pkt_valid_d  = (state_d == SEND);
    end

    logic [BASE_BYTES*8-1:0] base;
    assign base = {info_q, hdr_cnt_q, words_q};

`ifdef SIMON_PKT_CHECKSUM_EN
    logic [7:0] csum;
    always_comb begin
        csum = 8'd0;
        for (int i = 0; i < BASE_BYTES; i++) begin
            csum = csum ^ base[i*8 +: 8];
        end
    end
    assign bus.pkt_out = {base, csum};
`else
    assign bus.pkt_out = base;
`endif

    assign bus.data_ready = data_ready_q;
    assign bus.pkt_valid  = pkt_valid_q;
    assign bus.err        = err_q;
    assign bus.pkt_count  = pkt_count_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_simon_pkt_out.sv
module tb_simon_pkt_out;
  localparam int N = 16;
  localparam int B = 2;
`ifdef SIMON_PKT_CHECKSUM_EN
  localparam int PW = 88;
`else
  localparam int PW = 80;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic nR  = 1'b0;
  always #5 clk = ~clk;

  simon_pkt_out_if #(.N(N), .BLOCKS_PER_PKT(B)) bus ();
  logic [1:0] state_dbg;

  simon_pkt_out #(.N(N), .BLOCKS_PER_PKT(B), .MODE(4'h0)) dut (
    .clk     (clk),
    .nR      (nR),
    .bus     (bus),
    .state_o (state_dbg)
  );

  int n_vec  = 0;
  int n_fail = 0;
  logic [PW-1:0] exp_q[$];
  logic [1:0]    exp_err_q[$];
  logic [PW-1:0] mon_e;
  logic [1:0]    mon_err;

  function automatic logic [PW-1:0] mk_pkt(input logic [79:0] base);
`ifdef SIMON_PKT_CHECKSUM_EN
    logic [7:0] c;
    c = 8'd0;
    for (int i = 0; i < 10; i++) c = c ^ base[i*8 +: 8];
    return {base, c};
`else
    return base;
`endif
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: present one beat and hold it until accepted (bounded)
  task automatic send_beat(input logic [7:0] info, input logic [7:0] cnt, input logic [31:0] d);
    logic rdy;
    int k;
    bus.data_valid = 1'b1;
    bus.info_in    = info;
    bus.count_in   = cnt;
    bus.data_in    = d;
    rdy = 1'b0;
    k = 0;
    while (!rdy && k < 50) begin
      rdy = bus.data_ready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!rdy) begin
      n_vec++;
      n_fail++;
      $display("FAIL beat_timeout: data_ready never seen, info %0h count %0h", info, cnt);
    end
    bus.data_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_ready"}, bus.data_ready, 0);
    check({tag, "_pkt_valid"}, bus.pkt_valid, 0);
    check({tag, "_pkt_out"}, bus.pkt_out, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_pkt_count"}, bus.pkt_count, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  task automatic apply_reset();
    nR = 1'b0;
    step();
    step();
    nR = 1'b1;
    check("ready_low_after_reset", bus.data_ready, 0);
    step();
    check("ready_high_in_idle", bus.data_ready, 1);
  endtask

  // scoreboard monitor: pops on every packet handshake and every err pulse
  initial begin
    forever begin
      @(negedge clk);
      if (nR) begin
        if (bus.pkt_valid && bus.pkt_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_pkt: got %0h expected none", bus.pkt_out);
          end else begin
            mon_e = exp_q.pop_front();
            check("pkt_out", bus.pkt_out, mon_e);
          end
        end
        if (bus.err != 2'd0) begin
          if (exp_err_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_err: got %0d expected 0", bus.err);
          end else begin
            mon_err = exp_err_q.pop_front();
            check("err_code", bus.err, mon_err);
          end
        end
      end
    end
  end

  initial begin
    bus.data_valid = 1'b0;
    bus.info_in    = 8'h00;
    bus.count_in   = 8'h00;
    bus.data_in    = '0;
    bus.pkt_ready  = 1'b1;

    // reset state
    step();
    step();
    check_reset_outputs("rst");
    nR = 1'b1;
    check("ready_low_after_reset", bus.data_ready, 0);
    step();
    check("ready_high_in_idle", bus.data_ready, 1);

    // basic two-block packet; second-beat header fields are ignored
    exp_q.push_back(mk_pkt(80'h90_00_4444_3333_2222_1111));
    send_beat(8'h90, 8'h00, 32'h2222_1111);
    check("collect_state", state_dbg, 1);
    send_beat(8'hFF, 8'h77, 32'h4444_3333);
    check("pkt_valid_latency", bus.pkt_valid, 1);
    check("ready_low_in_send", bus.data_ready, 0);
    check("pkt_count_after_1", bus.pkt_count, 1);
    step();
    check("pkt_valid_drop", bus.pkt_valid, 0);

    // header errors (pkt_count is now 1)
    exp_err_q.push_back(2'd1);
    send_beat(8'h90, 8'h05, 32'h0);
    check("err_count_mismatch", bus.err, 1);
    step();
    check("err_one_cycle", bus.err, 0);
    check("no_pkt_after_err", bus.pkt_valid, 0);
    check("count_kept_err1", bus.pkt_count, 1);

    exp_err_q.push_back(2'd1);
    send_beat(8'h93, 8'h09, 32'h0);
    check("err_priority", bus.err, 1);

    exp_err_q.push_back(2'd2);
    send_beat(8'h93, 8'h01, 32'h0);
    check("err_mode_mismatch", bus.err, 2);

    exp_err_q.push_back(2'd3);
    send_beat(8'h80, 8'h01, 32'h0);
    check("err_not_output", bus.err, 3);
    step();
    check("count_kept_err3", bus.pkt_count, 1);
    check("idle_after_err", state_dbg, 0);

    // zero-fill: one beat, words cleared
    exp_q.push_back(mk_pkt(80'hB0_01_0000_0000_0000_0000));
    send_beat(8'hB0, 8'h01, 32'hDEAD_BEEF);
    check("zf_pkt_valid", bus.pkt_valid, 1);
    check("zf_pkt_count", bus.pkt_count, 2);
    step();

    // back-pressure: pkt_ready low for 10 cycles with next beat waiting
    bus.pkt_ready = 1'b0;
    exp_q.push_back(mk_pkt(80'h90_02_D4D4_C3C3_B2B2_A1A1));
    send_beat(8'h90, 8'h02, 32'hB2B2_A1A1);
    send_beat(8'h90, 8'h02, 32'hD4D4_C3C3);
    exp_q.push_back(mk_pkt(80'h90_03_0004_0003_F00D_0001));
    bus.data_valid = 1'b1;
    bus.info_in    = 8'h90;
    bus.count_in   = 8'h03;
    bus.data_in    = 32'hF00D_0001;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_ready_low", bus.data_ready, 0);
      check("stall_valid_held", bus.pkt_valid, 1);
      check("stall_pkt_stable", bus.pkt_out, mk_pkt(80'h90_02_D4D4_C3C3_B2B2_A1A1));
    end
    bus.pkt_ready = 1'b1;
    step();
    check("handshake_valid_low", bus.pkt_valid, 0);
    check("handshake_ready_high", bus.data_ready, 1);
    check("beat_not_yet_taken", bus.pkt_count, 3);
    step();
    check("beat_taken_next_cycle", bus.pkt_count, 4);
    bus.data_valid = 1'b0;
    send_beat(8'h90, 8'h03, 32'h0004_0003);
    step();

    // 257 packets from reset: headers 0..255 then 0
    apply_reset();
    for (int i = 0; i < 257; i++) begin
      logic [7:0]  c;
      logic [15:0] w0, w1, w2, w3;
      c  = i[7:0];
      w0 = i[15:0];
      w1 = ~i[15:0];
      w2 = 16'(i * 3);
      w3 = 16'h5A5A;
      exp_q.push_back(mk_pkt({8'h90, c, w3, w2, w1, w0}));
      send_beat(8'h90, c, {w1, w0});
      send_beat(8'h90, c, {w3, w2});
    end
    step();
    check("wrap_pkt_count", bus.pkt_count, 1);

    // asynchronous reset mid-collection discards the partial packet
    send_beat(8'h90, 8'h01, 32'h1234_5678);
    check("mid_collect_state", state_dbg, 1);
    #2;
    nR = 1'b0;
    #1;
    check_reset_outputs("async");
    step();
    step();
    nR = 1'b1;
    step();
    exp_q.push_back(mk_pkt(80'h90_00_0F0F_0E0E_0D0D_0C0C));
    send_beat(8'h90, 8'h00, 32'h0D0D_0C0C);
    send_beat(8'h90, 8'h00, 32'h0F0F_0E0E);
    check("fresh_pkt_count", bus.pkt_count, 1);

    // drain and final report
    for (int k = 0; k < 20 && (exp_q.size() != 0 || exp_err_q.size() != 0); k++) step();
    step();
    check("pkt_queue_empty", exp_q.size(), 0);
    check("err_queue_empty", exp_err_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
